// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider controller. One quotient bit is
// resolved per clock in ITER; PREP converts operands to magnitudes and FIXUP
// restores the result signs. The control unit pulses start and waits for done.
//
// Optional feature (compile-time macro DIV_EARLY_EXIT_EN): when
// |dividend| < |divisor| the ITER phase is skipped (quotient 0, remainder =
// dividend). Results are identical with or without it; only latency changes.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request, sampled only in IDLE (operands latched with it)
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   dividend     numerator
//   divisor      denominator
//   flush        synchronous abort; back to IDLE, no done, outputs held
//   busy         high while an operation is in flight
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     result, held until the next done
//   remainder    result (sign follows dividend), held until the next done
//   div_by_zero  set with done when the latched divisor was zero
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_q;     // dividend as latched
  logic [WIDTH-1:0] dvs_q;     // divisor as latched
  logic             sgn_en;    // is_signed as latched
  logic             sign_q;    // quotient must be negated
  logic             sign_r;    // remainder must be negated
  logic             dbz;       // latched divisor was zero
  logic [WIDTH-1:0] dvs_mag;   // |divisor|
  logic [WIDTH-1:0] acc_a;     // dividend shifts out / quotient bits shift in
  logic [WIDTH:0]   acc_p;     // partial remainder, one guard bit for the sign
  logic [CW-1:0]    cnt;

  // Magnitudes of the latched operands. -2^(WIDTH-1) negates to itself, which
  // read as unsigned is exactly the required magnitude.
  logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c;
  logic             dvs_zero, early_c;

  assign dvd_mag_c = (sgn_en && dvd_q[WIDTH-1]) ? (~dvd_q + 1'b1) : dvd_q;
  assign dvs_mag_c = (sgn_en && dvs_q[WIDTH-1]) ? (~dvs_q + 1'b1) : dvs_q;
  assign dvs_zero  = (dvs_q == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign early_c = !dvs_zero && (dvd_mag_c < dvs_mag_c);
`else
  assign early_c = 1'b0;
`endif

  // One restoring step: shift {P,A} left, trial-subtract the divisor. A set
  // guard bit means the trial went negative, so the shifted P is kept.
  logic [WIDTH:0] p_shift, p_trial;
  logic           p_neg;

  assign p_shift = {acc_p[WIDTH-1:0], acc_a[WIDTH-1]};
  assign p_trial = p_shift - {1'b0, dvs_mag};
  assign p_neg   = p_trial[WIDTH];

  // Sign restoration applied in FIXUP.
  logic [WIDTH-1:0] q_fix, r_fix;

  assign q_fix = sign_q ? (~acc_a + 1'b1) : acc_a;
  assign r_fix = sign_r ? (~acc_p[WIDTH-1:0] + 1'b1) : acc_p[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_PREP;
      S_PREP:  state_nxt = (dvs_zero || early_c) ? S_FIXUP : S_ITER;
      S_ITER:  if (cnt == '0) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Datapath and registered outputs.
  // NOTE: every datapath register is reset as well, so a reset mid-operation
  // leaves no stale accumulator or counter contents behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      sgn_en      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      dvs_mag     <= '0;
      acc_a       <= '0;
      acc_p       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // busy and done trail the state register by one cycle; flush drops
      // them on the same edge that returns the FSM to IDLE.
      busy <= (state != S_IDLE) && !flush;
      done <= (state == S_DONE) && !flush;

      unique case (state)
        S_IDLE: begin
          if (start && !flush) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            sgn_en <= is_signed;
          end
        end
        S_PREP: begin
          sign_q  <= sgn_en & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          sign_r  <= sgn_en & dvd_q[WIDTH-1];
          dbz     <= dvs_zero;
          dvs_mag <= dvs_mag_c;
          cnt     <= CW'(WIDTH - 1);
          if (early_c) begin
            acc_a <= '0;
            acc_p <= {1'b0, dvd_mag_c};
          end else begin
            acc_a <= dvd_mag_c;
            acc_p <= '0;
          end
        end
        S_ITER: begin
          acc_p <= p_neg ? p_shift : p_trial;
          acc_a <= {acc_a[WIDTH-2:0], ~p_neg};
          cnt   <= cnt - 1'b1;
        end
        S_FIXUP: begin
          if (dbz) begin
            acc_a <= '1;
            acc_p <= {1'b0, dvd_q};
          end else begin
            acc_a <= q_fix;
            acc_p <= {1'b0, r_fix};
          end
        end
        S_DONE: begin
          if (!flush) begin
            quotient    <= acc_a;
            remainder   <= acc_p[WIDTH-1:0];
            div_by_zero <= dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer (WIDTH=32). Expected results come from
// 64-bit integer division, which truncates toward zero and gives the remainder
// the sign of the dividend.
module tb_div_sequencer;

  localparam int W = 32;
  localparam int LAT_FULL = W + 3;
  localparam int LAT_SHORT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  // Results of the most recent completed operation, from the model.
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  div_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output int lat);
    longint sa, sb, abs_a, abs_b;
    sa = sg ? {{32{a[W-1]}}, a} : {32'b0, a};
    sb = sg ? {{32{b[W-1]}}, b} : {32'b0, b};
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
      lat = LAT_SHORT;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
      lat = LAT_FULL;
      abs_a = (sa < 0) ? -sa : sa;
      abs_b = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_EXIT_EN
      if (abs_a < abs_b) lat = LAT_SHORT;
`else
      if (abs_a < abs_b) lat = LAT_FULL;
`endif
    end
  endfunction

  // Launch one operation (start sampled at edge 0) and watch it for a bounded
  // number of edges. pulse_at >= 1 re-asserts start before that edge.
  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_at, input string tag);
    logic [W-1:0] eq, er, q0, r0;
    logic         ez, busy_ok, stable_ok;
    int           lat, done_edge, done_cnt;
    model(sg, a, b, eq, er, ez, lat);
    q0 = last_q;
    r0 = last_r;
    done_edge = -1;
    done_cnt = 0;
    busy_ok = 1'b1;
    stable_ok = 1'b1;
    @(negedge clk);
    is_signed = sg;
    dividend = a;
    divisor = b;
    start = 1'b1;
    for (int e = 0; e <= lat + 4; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      if (e >= 1 && e <= lat && busy !== 1'b1) busy_ok = 1'b0;
      if (e < lat && (quotient !== q0 || remainder !== r0)) stable_ok = 1'b0;
      @(negedge clk);
      // Scramble operand inputs to show the latched copies are used.
      start = (e + 1 == pulse_at);
      is_signed = 1'($urandom);
      dividend = $urandom;
      divisor = $urandom;
    end
    start = 1'b0;
    check({tag, "_done_edge"}, 64'(done_edge), 64'(lat));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy"}, {63'b0, busy_ok}, 64'd1);
    check({tag, "_stable"}, {63'b0, stable_ok}, 64'd1);
    check({tag, "_busy_end"}, {63'b0, busy}, 64'd0);
    check({tag, "_q"}, {32'b0, quotient}, {32'b0, eq});
    check({tag, "_r"}, {32'b0, remainder}, {32'b0, er});
    check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, ez});
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  // Over n edges neither busy nor done may rise.
  task automatic watch_idle(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check(tag, {63'b0, seen}, 64'd0);
  endtask

  task automatic check_outputs_held(input string tag);
    check({tag, "_q"}, {32'b0, quotient}, {32'b0, last_q});
    check({tag, "_r"}, {32'b0, remainder}, {32'b0, last_r});
    check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, last_z});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q"}, {32'b0, quotient}, 64'd0);
    check({tag, "_r"}, {32'b0, remainder}, 64'd0);
    check({tag, "_flags"}, {61'b0, busy, done, div_by_zero}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed arithmetic cases
    run_op(1'b0, 32'd100, 32'd7, -1, "u100_7");
    run_op(1'b1, -32'sd100, 32'd7, -1, "sm100_7");
    run_op(1'b1, 32'd100, -32'sd7, -1, "s100_m7");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "s_ovf");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, "u_big");
    run_op(1'b0, 32'h0000_1234, 32'd0, -1, "dbz");
    run_op(1'b0, 32'd3, 32'd10, -1, "small_3_10");
    run_op(1'b1, -32'sd3, 32'd10, -1, "small_m3_10");

    // start during ITER and during DONE must not queue a second operation
    run_op(1'b0, 32'd1000, 32'd9, 10, "start_iter");
    watch_idle(45, "start_iter_no_second");
    run_op(1'b1, -32'sd1000, -32'sd9, LAT_FULL, "start_done");
    watch_idle(45, "start_done_no_second");

    // flush sampled at edge 5 of a running op
    @(negedge clk);
    is_signed = 1'b0;
    dividend = 32'd77;
    divisor = 32'd5;
    start = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      flush = (e == 4);
    end
    @(posedge clk);
    #1;
    check("flush_busy_drop", {63'b0, busy}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    watch_idle(45, "flush_no_done");
    check_outputs_held("flush_held");

    // flush and start together in IDLE: start is dropped
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    dividend = 32'd50;
    divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    watch_idle(45, "flush_start_dropped");
    check_outputs_held("flush_start_held");

    // Recovery after the aborts
    run_op(1'b0, 32'd77, 32'd5, -1, "after_flush");

    // Asynchronous reset mid-ITER clears everything at once
    @(negedge clk);
    is_signed = 1'b0;
    dividend = 32'd12345;
    divisor = 32'd11;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd12345, 32'd11, -1, "after_reset");

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 300);
        2: rb = -W'($urandom_range(1, 300));
        default: rb = (i % 8 == 3) ? '0 : (ra >> $urandom_range(0, 31));
      endcase
      run_op(rs, ra, rb, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller that sequences one restoring-division step per clock.
- Serves the CPU's DIV instruction; the control unit pulses start and waits for done before writing LO (quotient) and HI (remainder).
- Replaces the fully-unrolled combinational divider path, removing the long critical path.
- Handles signed and unsigned operands, divide-by-zero, and abort.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with start
- dividend  in  WIDTH  numerator; latched with start
- divisor  in  WIDTH  denominator; latched with start
- flush  in  1  synchronous abort; return to IDLE, no done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; quotient/remainder valid from this cycle on
- quotient  out  WIDTH  result, held until next done
- remainder  out  WIDTH  result, held until next done
- div_by_zero  out  1  high with done when latched divisor was 0; held with results

Behaviour:
- Reset (rst_n low, any state, mid-operation included):
  - state=IDLE.
  - busy, done, div_by_zero = 0; quotient, remainder = 0; internal accumulator/counter = 0.
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE:
  - start=1 on an edge: latch operands and is_signed; go to PREP.
  - start=0: hold results, busy=0.
- PREP (1 cycle):
  - Record sign_q = is_signed & (dividend[MSB] ^ divisor[MSB]) and sign_r = is_signed & dividend[MSB].
  - Convert operands to magnitudes (negate if signed and MSB set; magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) unsigned).
  - Clear the (WIDTH+1)-bit partial remainder; load counter=WIDTH-1; go to ITER.
  - If divisor==0: go directly to FIXUP with dbz flag set.
- ITER (WIDTH cycles): each edge performs one step:
  - Shift {P,A} left 1.
  - P = P - magnitude(divisor), computed WIDTH+1 bits wide.
  - If P is negative: restore P and set A[0]=0; otherwise A[0]=1.
  - At counter==0 go to FIXUP; else decrement.
- FIXUP (1 cycle):
  - quotient = sign_q ? -A : A; remainder = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - dbz case: quotient = all ones, remainder = dividend as latched (no sign fixup).
  - Go to DONE.
- DONE (1 cycle): done=1, busy=1, then IDLE.
  - A start in DONE is ignored; the next start is accepted only in IDLE.
- Latency: done is high in the cycle after edge WIDTH+3 counting the start-sampling edge as edge 0 (36 cycles for WIDTH=32).
  - dbz case: edge 3.
- Output registers change only on entry to DONE; they are stable during busy.
- start while busy: ignored, no queueing.
- flush:
  - Has priority over all transitions except reset.
  - Forces IDLE on the next edge; outputs keep their previous values; done is never asserted for the aborted op.
  - flush and start together in IDLE: flush wins, start is dropped.
- Overflow -2^(WIDTH-1) / -1 (signed): quotient = 0x80000000, remainder = 0, no flag.
- Remainder sign follows the dividend; |remainder| < |divisor|.

Optional Feature:
- DIV_EARLY_EXIT_EN defined:
  - In PREP, if divisor!=0 and magnitude(dividend) < magnitude(divisor), skip ITER.
  - Go to FIXUP with A=0, P=magnitude(dividend), then apply normal sign fixup.
  - done at edge 3.
- Not defined: every non-zero-divisor operation takes the full WIDTH iterations.
- Results are identical either way; only latency differs.

Test Plan:
- Unsigned 100 / 7, is_signed=0 -> quotient 14, remainder 2, div_by_zero 0. done exactly one cycle, at edge 35; busy high from edge 1 through done cycle.
- Signed -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2). Signed 100 / -7 -> quotient -14, remainder 2.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned same operands -> quotient 0, remainder 0x80000000.
- Divisor 0, dividend 0x1234 -> done at edge 3; quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1.
- Start pulse at edge 10 of a running op -> ignored, single done. flush at edge 5 -> IDLE next edge, no done, outputs unchanged. rst_n low mid-ITER -> all outputs 0 immediately.
- With DIV_EARLY_EXIT_EN, 3 / 10 -> quotient 0, remainder 3, done at edge 3. Without the macro -> same result, done at edge 35.
